// File: rtl/mant_mul_iter_if.sv
// Operand/result bundle for the iterative mantissa multiplier.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface mant_mul_iter_if #(
    parameter int DWIDTH = 11
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DWIDTH-1:0]     a_i;
    logic [DWIDTH-1:0]     b_i;
    logic                  norm_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [2*DWIDTH-1:0]   prod_o;
    logic [DWIDTH-1:0]     mant_o;
    logic [1:0]            exp_inc_o;
    logic                  inexact_o;

    modport slave (
        input  in_valid_i, a_i, b_i, norm_i, out_ready_i,
        output in_ready_o, out_valid_o, prod_o, mant_o, exp_inc_o, inexact_o
    );

    modport master (
        output in_valid_i, a_i, b_i, norm_i, out_ready_i,
        input  in_ready_o, out_valid_o, prod_o, mant_o, exp_inc_o, inexact_o
    );
endinterface

// File: rtl/mant_mul_iter.sv
// Iterative mantissa multiplier: RADIX_BITS multiplier bits per cycle, then an
// optional normalise + round-to-nearest-even step; result held until accepted.
module mant_mul_iter #(
    parameter int DWIDTH     = 11,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mant_mul_iter_if.slave   bus,
    output logic [1:0]       dbg_state
);
    localparam int ITER = (DWIDTH + RADIX_BITS - 1) / RADIX_BITS;
    localparam int BW   = ITER * RADIX_BITS;
    localparam int PW   = 2 * DWIDTH;
    localparam int CW   = (ITER < 2) ? 1 : $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       a_sh_q;
    logic [BW-1:0]       b_q;
    logic                norm_q;
    logic [PW-1:0]       acc_q;
    logic [CW-1:0]       cnt_q;
    logic [PW-1:0]       prod_q;
    logic [DWIDTH-1:0]   mant_q;
    logic [1:0]          exp_inc_q;
    logic                inexact_q;

    logic [PW-1:0]       pp;
    logic [DWIDTH-1:0]   m_sel;
    logic [DWIDTH-1:0]   mant_n;
    logic [1:0]          exp_n;
    logic                top, guard, sticky, round_up;

    // The product is below 2^PW, so accumulating modulo 2^PW stays exact and
    // multiplicand bits shifted past PW can be dropped.
    assign pp = a_sh_q * PW'(b_q[RADIX_BITS-1:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid_i) state_d = CALC;
            CALC:    if (cnt_q == CW'(ITER - 1)) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        top    = acc_q[PW-1];
        m_sel  = acc_q[PW-2:DWIDTH-1];
        guard  = acc_q[DWIDTH-2];
        sticky = |acc_q[DWIDTH-3:0];
        if (top) begin
            m_sel  = acc_q[PW-1:DWIDTH];
            guard  = acc_q[DWIDTH-1];
            sticky = |acc_q[DWIDTH-2:0];
        end
        round_up = guard & (sticky | m_sel[0]);
        mant_n   = m_sel + {{(DWIDTH-1){1'b0}}, round_up};
        exp_n    = {1'b0, top};
        // Rounding an all-ones mantissa carries out into the next binade.
        if (round_up && (&m_sel)) begin
            mant_n = {1'b1, {(DWIDTH-1){1'b0}}};
            exp_n  = {1'b0, top} + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh_q    <= '0;
            b_q       <= '0;
            norm_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mant_q    <= '0;
            exp_inc_q <= '0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        a_sh_q <= PW'(bus.a_i);
                        b_q    <= BW'(bus.b_i);
                        norm_q <= bus.norm_i;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                CALC: begin
                    acc_q  <= acc_q + pp;
                    a_sh_q <= a_sh_q << RADIX_BITS;
                    b_q    <= b_q >> RADIX_BITS;
                    cnt_q  <= cnt_q + CW'(1);
                end
                ROUND: begin
                    prod_q    <= acc_q;
                    mant_q    <= norm_q ? mant_n : acc_q[PW-1:DWIDTH];
                    exp_inc_q <= norm_q ? exp_n : 2'd0;
                    inexact_q <= norm_q & (guard | sticky);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.prod_o      = prod_q;
    assign bus.mant_o      = mant_q;
    assign bus.exp_inc_o   = exp_inc_q;
    assign bus.inexact_o   = inexact_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_mant_mul_iter.sv
// Bench for mant_mul_iter: three instances (RADIX_BITS 1, 2, 11) driven with
// hand-computed vectors; a negedge monitor checks results against a queue.
module tb_mant_mul_iter;
  localparam int W = 38;

  typedef struct packed {
    logic [10:0] a;
    logic [10:0] b;
    logic        norm;
    logic [21:0] prod;
    logic [10:0] mant;
    logic [1:0]  e;
    logic        inx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        in_valid[3];
  logic [10:0] a[3];
  logic [10:0] b[3];
  logic        norm[3];
  logic        out_ready[3];
  logic        in_ready[3];
  logic        out_valid[3];
  logic [21:0] prod[3];
  logic [10:0] mant[3];
  logic [1:0]  exp_inc[3];
  logic        inexact[3];
  logic [1:0]  dbg_state[3];

  logic [W-1:0] exp_q[$];
  vec_t         vecs[9];
  int           lat_exp[3] = '{12, 7, 2};
  int           acc_edge[3];
  int           hs_edge[3];
  logic         prev_valid[3];
  logic         prev_ready[3];
  logic [35:0]  held[3];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int RB = (k == 0) ? 1 : ((k == 1) ? 2 : 11);
    mant_mul_iter_if #(.DWIDTH(11)) bus ();
    mant_mul_iter #(.DWIDTH(11), .RADIX_BITS(RB)) u_dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state(dbg_state[k])
    );
    assign bus.in_valid_i  = in_valid[k];
    assign bus.a_i         = a[k];
    assign bus.b_i         = b[k];
    assign bus.norm_i      = norm[k];
    assign bus.out_ready_i = out_ready[k];
    assign in_ready[k]     = bus.in_ready_o;
    assign out_valid[k]    = bus.out_valid_o;
    assign prod[k]         = bus.prod_o;
    assign mant[k]         = bus.mant_o;
    assign exp_inc[k]      = bus.exp_inc_o;
    assign inexact[k]      = bus.inexact_o;
  end

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h @cycle %0d", name, k, act, req, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        if (out_valid[k] && !prev_valid[k])
          chk("latency", k, 64'(cyc - acc_edge[k]), 64'(lat_exp[k]));
        if (out_valid[k] && prev_valid[k] && !prev_ready[k]) begin
          chk("hold_stable", k, {prod[k], mant[k], exp_inc[k], inexact[k]}, held[k]);
          chk("in_ready_busy", k, in_ready[k], 0);
        end
        if (out_valid[k] && out_ready[k]) begin
          hs_edge[k] = cyc + 1;
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_output dut%0d actual=%0h required=none", k, prod[k]);
          end else begin
            logic [W-1:0] item;
            item = exp_q.pop_front();
            chk("dut_tag", k, 64'(k), item[37:36]);
            chk("prod", k, prod[k], item[35:14]);
            chk("mant", k, mant[k], item[13:3]);
            chk("exp_inc", k, exp_inc[k], item[2:1]);
            chk("inexact", k, inexact[k], item[0]);
          end
        end
        held[k] = {prod[k], mant[k], exp_inc[k], inexact[k]};
      end
      prev_valid[k] = out_valid[k] && !rst;
      prev_ready[k] = out_ready[k];
    end
  end

  // driver tasks
  task automatic send(input int k, input int v, output int accepted_edge);
    int  n;
    bit  done;
    @(posedge clk); #1;
    in_valid[k] = 1'b1;
    a[k]        = vecs[v].a;
    b[k]        = vecs[v].b;
    norm[k]     = vecs[v].norm;
    done = 0;
    n = 0;
    accepted_edge = -1;
    while (!done && n < 300) begin
      @(negedge clk);
      if (in_ready[k] && !rst) begin
        exp_q.push_back({2'(k), vecs[v].prod, vecs[v].mant, vecs[v].e, vecs[v].inx});
        acc_edge[k]   = cyc + 1;
        accepted_edge = cyc + 1;
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid[k] = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout dut%0d actual=not_accepted required=accepted", k);
    end
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    @(negedge clk);
    while (!out_valid[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[k]) begin
      errors++;
      checks++;
      $display("FAIL valid_timeout dut%0d actual=0 required=1", k);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input int k);
    chk("rst_out_valid", k, out_valid[k], 0);
    chk("rst_in_ready", k, in_ready[k], 1);
    chk("rst_prod", k, prod[k], 0);
    chk("rst_mant", k, mant[k], 0);
    chk("rst_exp_inc", k, exp_inc[k], 0);
    chk("rst_inexact", k, inexact[k], 0);
    chk("rst_state", k, dbg_state[k], 0);
  endtask

  initial begin
    int e1, e2;
    //            a        b       norm  prod        mant     e     inx
    vecs[0] = {11'h400, 11'h400, 1'b1, 22'h100000, 11'h400, 2'd0, 1'b0};
    vecs[1] = {11'h7FF, 11'h7FF, 1'b1, 22'h3FF001, 11'h7FE, 2'd1, 1'b1};
    vecs[2] = {11'h7FF, 11'h7FF, 1'b0, 22'h3FF001, 11'h7FE, 2'd0, 1'b0};
    vecs[3] = {11'h5A8, 11'h5A8, 1'b1, 22'h1FFE40, 11'h400, 2'd1, 1'b1};
    vecs[4] = {11'h401, 11'h600, 1'b1, 22'h180600, 11'h602, 2'd0, 1'b1};
    vecs[5] = {11'h7FF, 11'h401, 1'b1, 22'h2003FF, 11'h400, 2'd1, 1'b1};
    vecs[6] = {11'h000, 11'h7FF, 1'b1, 22'h000000, 11'h000, 2'd0, 1'b0};
    vecs[7] = {11'h5A8, 11'h5A8, 1'b0, 22'h1FFE40, 11'h3FF, 2'd0, 1'b0};
    vecs[8] = {11'h7FF, 11'h400, 1'b1, 22'h1FFC00, 11'h7FF, 2'd0, 1'b0};

    // operands presented during reset must not be captured
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b1;
      a[k]         = 11'h7FF;
      b[k]         = 11'h7FF;
      norm[k]      = 1'b1;
      out_ready[k] = 1'b1;
      prev_valid[k] = 1'b0;
      prev_ready[k] = 1'b1;
      acc_edge[k]  = 0;
      hs_edge[k]   = 0;
      held[k]      = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset_state(k);

    for (int v = 0; v < 9; v++) begin
      send(0, v, e1);
      drain();
    end
    for (int k = 1; k < 3; k++) begin
      send(k, 1, e1); drain();
      send(k, 3, e1); drain();
      send(k, 4, e1); drain();
      send(k, 7, e1); drain();
    end

    // backpressure with a second operation pending
    for (int k = 0; k < 3; k++) begin
      out_ready[k] = 1'b0;
      send(k, 1, e1);
      fork
        send(k, 4, e2);
        begin
          wait_valid(k);
          repeat (5) @(posedge clk);
          #1 out_ready[k] = 1'b1;
        end
      join
      chk("accept_after_hs", k, 64'(e2 - hs_edge[k]), 1);
      drain();
    end

    // reset in the 4th CALC cycle, with operands offered during reset
    send(0, 1, e1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("calc_state", 0, dbg_state[0], 1);
    #1;
    rst = 1'b1;
    in_valid[0] = 1'b1;
    a[0] = 11'h123;
    b[0] = 11'h456;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_state(0);
    send(0, 5, e1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
